esm_dispatch_ctrl: RTL

- Sits beside the ESM dependency-analysis core, at the consuming end of its `buffer_index` / `ready_index` interface.
- Owns the `bs`-entry instruction buffer:
  - allocates the slot index handed to the dependency core with each new instruction;
  - stores the instruction word;
  - queues slot indices the core reports as ready and issues them to execution over a valid/ready handshake;
  - frees slots on completion.

---
 rtl/esm_pkg.sv | 15 +
 rtl/esm_index_fifo.sv | 63 ++++++
 rtl/esm_dispatch_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/esm_pkg.sv
// Definitions shared by the ESM dispatch controller and the dependency core (IRT/IDT):
// the per-slot lifecycle encoding and the default buffer geometry.
package esm_pkg;

    localparam int unsigned ESM_BS      = 16;
    localparam int unsigned ESM_INSTR_W = 32;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_WAIT   = 2'd1,
        SLOT_QUEUED = 2'd2,
        SLOT_ISSUED = 2'd3
    } slot_state_t;

endpackage

// File: rtl/esm_index_fifo.sv
// Circular FIFO of slot indices with wrapping pointers and an occupancy count.
// The head entry is read combinationally. Push into a full FIFO is allowed only when it pops in the same cycle.
module esm_index_fifo
    import esm_pkg::*;
#(
    parameter int unsigned DEPTH = ESM_BS,
    parameter int unsigned W     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/esm_dispatch_ctrl.sv
// Instruction buffer owner for the ESM core: allocates slots, stores words,
// queues dependency-free slots for issue and frees slots on completion.
module esm_dispatch_ctrl
    import esm_pkg::*;
#(
    parameter int unsigned Instr_word_size = ESM_INSTR_W,
    parameter int unsigned bs              = ESM_BS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [Instr_word_size-1:0] instr_in,
    output logic [$clog2(bs)-1:0]      alloc_index,
    input  logic                       rdy_valid,
    input  logic [$clog2(bs)-1:0]      rdy_index,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [Instr_word_size-1:0] issue_instr,
    output logic [$clog2(bs)-1:0]      issue_index,
    input  logic                       done_valid,
    input  logic [$clog2(bs)-1:0]      done_index,
    output logic [$clog2(bs):0]        free_count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int unsigned bs_bits = $clog2(bs);

    slot_state_t                r_state [bs];
    slot_state_t                w_state_nxt [bs];
    logic [Instr_word_size-1:0] r_mem [bs];
    logic [bs_bits:0]           r_free_count;
    logic                       r_err;

    logic [bs_bits-1:0] w_alloc_idx;
    logic               w_found;
    logic               w_alloc;
    logic               w_rdy_ok;
    logic               w_rdy_bad;
    logic               w_done_ok;
    logic               w_done_bad;
    logic               w_pop;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [bs_bits-1:0] w_head;
    logic [bs_bits:0]   w_fifo_count;

    // Lowest-numbered FREE slot; a slot freed this cycle is only seen next cycle.
    always_comb begin
        w_alloc_idx = '0;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < bs; i++) begin
            if (!w_found && r_state[i] == SLOT_FREE) begin
                w_found     = 1'b1;
                w_alloc_idx = bs_bits'(i);
            end
        end
    end

    assign alloc_index = w_alloc_idx;
    assign free_count  = r_free_count;
    assign full        = (r_free_count == '0);
    assign empty       = (r_free_count == (bs_bits+1)'(bs));
    assign in_ready    = !full;
    assign err         = r_err;

    assign w_alloc    = in_valid && in_ready;
    assign w_rdy_ok   = rdy_valid && (r_state[rdy_index] == SLOT_WAIT);
    assign w_rdy_bad  = rdy_valid && (r_state[rdy_index] != SLOT_WAIT);
    assign w_done_ok  = done_valid && (r_state[done_index] == SLOT_ISSUED);
    assign w_done_bad = done_valid && (r_state[done_index] != SLOT_ISSUED);

    assign issue_valid = !w_fifo_empty;
    assign w_pop       = issue_valid && issue_ready;
    assign issue_index = issue_valid ? w_head : '0;
    assign issue_instr = issue_valid ? r_mem[w_head] : '0;

    esm_index_fifo #(
        .DEPTH (bs),
        .W     (bs_bits)
    ) u_ready_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .i_push      (w_rdy_ok),
        .i_push_data (rdy_index),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Each transition starts from a different state, so all four can land in one cycle on distinct slots.
    always_comb begin
        for (int unsigned i = 0; i < bs; i++) begin
            w_state_nxt[i] = r_state[i];
        end
        if (w_alloc) begin
            w_state_nxt[w_alloc_idx] = SLOT_WAIT;
        end
        if (w_rdy_ok) begin
            w_state_nxt[rdy_index] = SLOT_QUEUED;
        end
        if (w_pop) begin
            w_state_nxt[w_head] = SLOT_ISSUED;
        end
        if (w_done_ok) begin
            w_state_nxt[done_index] = SLOT_FREE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < bs; i++) begin
                r_state[i] <= SLOT_FREE;
            end
        end else begin
            for (int unsigned i = 0; i < bs; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_mem[w_alloc_idx] <= instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_free_count <= (bs_bits+1)'(bs);
            r_err        <= 1'b0;
        end else begin
            case ({w_alloc, w_done_ok})
                2'b10:   r_free_count <= r_free_count - (bs_bits+1)'(1);
                2'b01:   r_free_count <= r_free_count + (bs_bits+1)'(1);
                default: r_free_count <= r_free_count;
            endcase
            if (w_rdy_bad || w_done_bad) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
